// File: rtl/lb2drp_mc.sv
// Local-bus to multi-channel DRP bridge: edge-triggered LB commands are queued in a small FIFO
// and run one at a time on the DRP port picked by the upper address bits, with a timeout.
module lb2drp_mc #(
  parameter int C_ADDR_WIDTH   = 12,
  parameter int C_DATA_WIDTH   = 16,
  parameter int C_CH_NUM       = 4,
  parameter int C_CH_SEL_WIDTH = 2,
  parameter int C_FIFO_DEPTH   = 4,
  parameter int C_TIMEOUT      = 1023
) (
  input  logic                                   CLK_I,
  input  logic                                   RST_I,
  input  logic [C_CH_SEL_WIDTH+C_ADDR_WIDTH-1:0] S_LB_WADDR,
  input  logic [C_DATA_WIDTH-1:0]                S_LB_WDATA,
  input  logic                                   S_LB_WREQ,
  input  logic [C_CH_SEL_WIDTH+C_ADDR_WIDTH-1:0] S_LB_RADDR,
  input  logic                                   S_LB_RREQ,
  output logic [C_DATA_WIDTH-1:0]                S_LB_RDATA,
  output logic                                   S_LB_RFINISH,
  output logic                                   S_LB_WFINISH,
  output logic                                   S_LB_ERR,
  output logic                                   S_LB_DROP,
  output logic                                   S_LB_BUSY,
  output logic [C_CH_NUM-1:0]                    M_DRPEN,
  output logic [C_CH_NUM-1:0]                    M_DRPWE,
  output logic [C_ADDR_WIDTH-1:0]                M_DRPADDR,
  output logic [C_DATA_WIDTH-1:0]                M_DRPDI,
  input  logic [C_CH_NUM-1:0]                    M_DRPRDY,
  input  logic [C_CH_NUM*C_DATA_WIDTH-1:0]       M_DRPDO
);
  localparam int LBA_W = C_CH_SEL_WIDTH + C_ADDR_WIDTH;
  localparam int ENT_W = 1 + LBA_W + C_DATA_WIDTH;
  localparam int PTR_W = $clog2(C_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [15:0] TMO_LAST = 16'(C_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t                    state_q, state_d;
  logic                      armed_q, armed_d, wreq_q, wreq_d, rreq_q, rreq_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      is_wr_q, is_wr_d;
  logic [C_CH_SEL_WIDTH-1:0] ch_q, ch_d;
  logic [15:0]               tmo_q, tmo_d;
  logic [C_CH_NUM-1:0]       drpen_q, drpen_d, drpwe_q, drpwe_d;
  logic [C_ADDR_WIDTH-1:0]   drpaddr_q, drpaddr_d;
  logic [C_DATA_WIDTH-1:0]   drpdi_q, drpdi_d, rdata_q, rdata_d;
  logic                      rfin_q, rfin_d, wfin_q, wfin_d, err_q, err_d, drop_q, drop_d;

  logic [ENT_W-1:0]          fifo_mem [C_FIFO_DEPTH];
  logic [ENT_W-1:0]          head;
  logic [C_CH_SEL_WIDTH-1:0] head_ch;
  logic [C_CH_NUM-1:0]       head_sel;
  logic                      w_edge, r_edge, w_ok, r_ok, pop;
  logic                      act_hit, act_rdy;
  logic [C_DATA_WIDTH-1:0]   act_do;
  logic [PTR_W-1:0]          r_slot;

  always_comb begin
    state_d   = state_q;
    armed_d   = 1'b1;
    wreq_d    = S_LB_WREQ;
    rreq_d    = S_LB_RREQ;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    is_wr_d   = is_wr_q;
    ch_d      = ch_q;
    tmo_d     = tmo_q;
    drpen_d   = '0;
    drpwe_d   = '0;
    drpaddr_d = drpaddr_q;
    drpdi_d   = drpdi_q;
    rdata_d   = rdata_q;
    rfin_d    = 1'b0;
    wfin_d    = 1'b0;
    err_d     = 1'b0;
    pop       = 1'b0;

    // armed_q keeps a level already high at reset release from counting as an edge
    w_edge = armed_q & S_LB_WREQ & ~wreq_q;
    r_edge = armed_q & S_LB_RREQ & ~rreq_q;
    w_ok   = w_edge && (count_q < CNT_W'(C_FIFO_DEPTH));
    r_ok   = r_edge && ((count_q + CNT_W'(w_ok)) < CNT_W'(C_FIFO_DEPTH));
    r_slot = wr_ptr_q + PTR_W'(w_ok);
    drop_d = (w_edge & ~w_ok) | (r_edge & ~r_ok);

    head     = fifo_mem[rd_ptr_q];
    head_ch  = head[C_DATA_WIDTH+LBA_W-1 -: C_CH_SEL_WIDTH];
    head_sel = '0;
    act_hit  = 1'b0;
    act_rdy  = 1'b0;
    act_do   = '0;
    for (int k = 0; k < C_CH_NUM; k++) begin
      if (head_ch == C_CH_SEL_WIDTH'(k)) head_sel[k] = 1'b1;
      if (ch_q == C_CH_SEL_WIDTH'(k)) begin
        act_hit = 1'b1;
        act_rdy = M_DRPRDY[k];
        act_do  = M_DRPDO[k*C_DATA_WIDTH +: C_DATA_WIDTH];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          is_wr_d   = head[ENT_W-1];
          ch_d      = head_ch;
          drpaddr_d = head[C_DATA_WIDTH +: C_ADDR_WIDTH];
          drpdi_d   = head[C_DATA_WIDTH-1:0];
          drpen_d   = head_sel;
          drpwe_d   = head[ENT_W-1] ? head_sel : '0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_d = '0;
        if (act_hit) begin
          state_d = ST_WAIT;
        end else begin
          wfin_d  = is_wr_q;
          rfin_d  = ~is_wr_q;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WAIT: begin
        if (act_rdy) begin
          wfin_d  = is_wr_q;
          rfin_d  = ~is_wr_q;
          if (!is_wr_q) rdata_d = act_do;
          state_d = ST_DONE;
        end else if (tmo_q == TMO_LAST) begin
          wfin_d  = is_wr_q;
          rfin_d  = ~is_wr_q;
          err_d   = 1'b1;
          if (!is_wr_q) rdata_d = '1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + PTR_W'(w_ok) + PTR_W'(r_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(w_ok) + CNT_W'(r_ok) - CNT_W'(pop);
  end

  // Write command takes the first free slot, a simultaneous read the one after it
  always_ff @(posedge CLK_I) begin
    if (w_ok) fifo_mem[wr_ptr_q] <= {1'b1, S_LB_WADDR, S_LB_WDATA};
    if (r_ok) fifo_mem[r_slot] <= {1'b0, S_LB_RADDR, {C_DATA_WIDTH{1'b0}}};
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q   <= ST_IDLE;
      armed_q   <= 1'b0;
      wreq_q    <= 1'b0;
      rreq_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      is_wr_q   <= 1'b0;
      ch_q      <= '0;
      tmo_q     <= '0;
      drpen_q   <= '0;
      drpwe_q   <= '0;
      drpaddr_q <= '0;
      drpdi_q   <= '0;
      rdata_q   <= '0;
      rfin_q    <= 1'b0;
      wfin_q    <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      wreq_q    <= wreq_d;
      rreq_q    <= rreq_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      is_wr_q   <= is_wr_d;
      ch_q      <= ch_d;
      tmo_q     <= tmo_d;
      drpen_q   <= drpen_d;
      drpwe_q   <= drpwe_d;
      drpaddr_q <= drpaddr_d;
      drpdi_q   <= drpdi_d;
      rdata_q   <= rdata_d;
      rfin_q    <= rfin_d;
      wfin_q    <= wfin_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
    end
  end

  assign S_LB_RDATA   = rdata_q;
  assign S_LB_RFINISH = rfin_q;
  assign S_LB_WFINISH = wfin_q;
  assign S_LB_ERR     = err_q;
  assign S_LB_DROP    = drop_q;
  assign S_LB_BUSY    = (count_q > CNT_W'(C_FIFO_DEPTH - 2));
  assign M_DRPEN      = drpen_q;
  assign M_DRPWE      = drpwe_q;
  assign M_DRPADDR    = drpaddr_q;
  assign M_DRPDI      = drpdi_q;
endmodule

// File: tb/tb_lb2drp_mc.sv
// Directed bench for lb2drp_mc: a default 4-channel instance and a 3-channel, short-timeout one.
module tb_lb2drp_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [13:0] a_waddr = '0, a_raddr = '0;
  logic [15:0] a_wdata = '0, a_rdata, a_drpdi;
  logic        a_wreq = 1'b0, a_rreq = 1'b0;
  logic        a_rfin, a_wfin, a_err, a_drop, a_busy;
  logic [3:0]  a_drpen, a_drpwe, a_rdy = '0;
  logic [11:0] a_drpaddr;
  logic [63:0] a_do = '0;

  logic [13:0] b_waddr = '0, b_raddr = '0;
  logic [15:0] b_wdata = '0, b_rdata, b_drpdi;
  logic        b_wreq = 1'b0, b_rreq = 1'b0;
  logic        b_rfin, b_wfin, b_err, b_drop, b_busy;
  logic [2:0]  b_drpen, b_drpwe, b_rdy = '0;
  logic [11:0] b_drpaddr;
  logic [47:0] b_do = '0;

  lb2drp_mc u_dut_a (
    .CLK_I(clk), .RST_I(rst),
    .S_LB_WADDR(a_waddr), .S_LB_WDATA(a_wdata), .S_LB_WREQ(a_wreq),
    .S_LB_RADDR(a_raddr), .S_LB_RREQ(a_rreq), .S_LB_RDATA(a_rdata),
    .S_LB_RFINISH(a_rfin), .S_LB_WFINISH(a_wfin), .S_LB_ERR(a_err),
    .S_LB_DROP(a_drop), .S_LB_BUSY(a_busy),
    .M_DRPEN(a_drpen), .M_DRPWE(a_drpwe), .M_DRPADDR(a_drpaddr), .M_DRPDI(a_drpdi),
    .M_DRPRDY(a_rdy), .M_DRPDO(a_do)
  );

  lb2drp_mc #(.C_CH_NUM(3), .C_TIMEOUT(16)) u_dut_b (
    .CLK_I(clk), .RST_I(rst),
    .S_LB_WADDR(b_waddr), .S_LB_WDATA(b_wdata), .S_LB_WREQ(b_wreq),
    .S_LB_RADDR(b_raddr), .S_LB_RREQ(b_rreq), .S_LB_RDATA(b_rdata),
    .S_LB_RFINISH(b_rfin), .S_LB_WFINISH(b_wfin), .S_LB_ERR(b_err),
    .S_LB_DROP(b_drop), .S_LB_BUSY(b_busy),
    .M_DRPEN(b_drpen), .M_DRPWE(b_drpwe), .M_DRPADDR(b_drpaddr), .M_DRPDI(b_drpdi),
    .M_DRPRDY(b_rdy), .M_DRPDO(b_do)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    a_wreq = 1'b1;
    repeat (3) tick();
    checks++; if (a_drpen !== 4'b0000) begin errors++; $display("FAIL rst_drpen: got %b want 0000", a_drpen); end
    checks++; if ({a_wfin, a_rfin, a_err, a_drop, a_busy} !== 5'b0) begin errors++; $display("FAIL rst_flags: got %b want 00000", {a_wfin, a_rfin, a_err, a_drop, a_busy}); end
    checks++; if (a_rdata !== 16'h0 || a_drpaddr !== 12'h0) begin errors++; $display("FAIL rst_data: rdata %h addr %h want 0", a_rdata, a_drpaddr); end
    checks++; if (b_drpen !== 3'b000 || b_rdata !== 16'h0) begin errors++; $display("FAIL rst_b: drpen %b rdata %h want 0", b_drpen, b_rdata); end
    rst = 1'b0;
    n = 0;
    repeat (6) begin tick(); if (a_drpen !== 4'b0000) n++; end
    checks++; if (n !== 0) begin errors++; $display("FAIL rst_level_not_edge: drpen cycles %0d want 0", n); end
    a_wreq = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_write();
    tick();
    a_waddr = {2'd1, 12'h344}; a_wdata = 16'h4544; a_wreq = 1'b1;
    tick(); a_wreq = 1'b0;
    tick();
    checks++; if (a_drpen !== 4'b0010 || a_drpwe !== 4'b0010) begin errors++; $display("FAIL wr_strobe: en %b we %b want 0010 0010", a_drpen, a_drpwe); end
    checks++; if (a_drpaddr !== 12'h344 || a_drpdi !== 16'h4544) begin errors++; $display("FAIL wr_addr_di: %h %h want 344 4544", a_drpaddr, a_drpdi); end
    repeat (5) tick();
    checks++; if (a_wfin !== 1'b0) begin errors++; $display("FAIL wr_early_finish: got %b want 0", a_wfin); end
    a_rdy = 4'b0010;
    tick(); a_rdy = 4'b0000;
    checks++; if (a_wfin !== 1'b1 || a_err !== 1'b0 || a_rfin !== 1'b0) begin errors++; $display("FAIL wr_finish: wfin %b err %b rfin %b want 1 0 0", a_wfin, a_err, a_rfin); end
    tick();
    checks++; if (a_wfin !== 1'b0 || a_drpaddr !== 12'h344) begin errors++; $display("FAIL wr_after: wfin %b addr %h want 0 344", a_wfin, a_drpaddr); end
    $display("test_write done");
  endtask

  task automatic test_read();
    tick();
    a_raddr = {2'd3, 12'hDDD}; a_rreq = 1'b1;
    tick(); a_rreq = 1'b0;
    tick();
    checks++; if (a_drpen !== 4'b1000 || a_drpwe !== 4'b0000 || a_drpaddr !== 12'hDDD) begin errors++; $display("FAIL rd_strobe: en %b we %b addr %h want 1000 0000 ddd", a_drpen, a_drpwe, a_drpaddr); end
    tick();
    a_rdy = 4'b0001; a_do[15:0] = 16'h1111;
    tick();
    checks++; if (a_rfin !== 1'b0) begin errors++; $display("FAIL rd_other_rdy: rfin %b want 0", a_rfin); end
    a_rdy = 4'b1000; a_do[63:48] = 16'hBEEF;
    tick(); a_rdy = 4'b0000;
    checks++; if (a_rfin !== 1'b1 || a_rdata !== 16'hBEEF || a_err !== 1'b0) begin errors++; $display("FAIL rd_finish: rfin %b rdata %h err %b want 1 beef 0", a_rfin, a_rdata, a_err); end
    a_do = '0;
    repeat (3) tick();
    checks++; if (a_rdata !== 16'hBEEF || a_rfin !== 1'b0) begin errors++; $display("FAIL rd_hold: rdata %h rfin %b want beef 0", a_rdata, a_rfin); end
    $display("test_read done");
  endtask

  task automatic test_hold();
    int ne, nf;
    ne = 0; nf = 0;
    a_rdy = 4'b0100;
    a_waddr = {2'd2, 12'h010}; a_wdata = 16'h0A0A;
    for (int i = 0; i < 20; i++) begin
      tick();
      a_wreq = (i < 3);
      if (a_drpen !== 4'b0000) ne++;
      if (a_wfin === 1'b1) nf++;
    end
    a_rdy = 4'b0000;
    checks++; if (ne !== 1) begin errors++; $display("FAIL hold_drpen_count: got %0d want 1", ne); end
    checks++; if (nf !== 1) begin errors++; $display("FAIL hold_wfin_count: got %0d want 1", nf); end
    $display("test_hold done");
  endtask

  task automatic test_bad_channel();
    int n;
    tick();
    b_raddr = {2'd1, 12'h055}; b_rreq = 1'b1;
    tick(); b_rreq = 1'b0;
    tick();
    checks++; if (b_drpen !== 3'b010) begin errors++; $display("FAIL bad_good_strobe: got %b want 010", b_drpen); end
    tick();
    b_rdy = 3'b010; b_do[31:16] = 16'h1234;
    tick(); b_rdy = 3'b000;
    checks++; if (b_rfin !== 1'b1 || b_rdata !== 16'h1234) begin errors++; $display("FAIL bad_good_read: rfin %b rdata %h want 1 1234", b_rfin, b_rdata); end
    tick();
    b_raddr = {2'd3, 12'h077}; b_rreq = 1'b1;
    tick(); b_rreq = 1'b0;
    tick();
    checks++; if (b_drpen !== 3'b000 || b_rfin !== 1'b0) begin errors++; $display("FAIL bad_no_strobe: en %b rfin %b want 000 0", b_drpen, b_rfin); end
    tick();
    checks++; if (b_rfin !== 1'b1 || b_err !== 1'b1 || b_rdata !== 16'h1234 || b_drpen !== 3'b000) begin errors++; $display("FAIL bad_finish: rfin %b err %b rdata %h en %b want 1 1 1234 000", b_rfin, b_err, b_rdata, b_drpen); end
    tick();
    b_raddr = {2'd2, 12'h0AA}; b_rreq = 1'b1;
    tick(); b_rreq = 1'b0;
    tick();
    checks++; if (b_drpen !== 3'b100) begin errors++; $display("FAIL tmo_strobe: got %b want 100", b_drpen); end
    n = 0;
    while (b_rfin !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (n !== 17) begin errors++; $display("FAIL tmo_latency: got %0d want 17", n); end
    checks++; if (b_err !== 1'b1 || b_rdata !== 16'hFFFF) begin errors++; $display("FAIL tmo_data: err %b rdata %h want 1 ffff", b_err, b_rdata); end
    $display("test_bad_channel done");
  endtask

  task automatic test_fifo_full();
    int n, nr;
    nr = 0;
    a_rdy = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      tick();
      a_waddr = {2'd0, 12'(i)}; a_wdata = 16'(i); a_wreq = 1'b1;
      tick(); a_wreq = 1'b0;
      checks++; if (a_drop !== (i == 5)) begin errors++; $display("FAIL full_drop[%0d]: got %b want %b", i, a_drop, (i == 5)); end
      checks++; if (a_busy !== (i >= 3)) begin errors++; $display("FAIL full_busy[%0d]: got %b want %b", i, a_busy, (i >= 3)); end
    end
    for (int j = 0; j < 6; j++) begin
      n = 9;
      if (j > 0) begin
        n = 0;
        while (a_drpen === 4'b0000 && n < 10) begin tick(); n++; end
        checks++; if (a_drpen !== 4'b0001 || a_drpaddr !== ((j < 5) ? 12'(j) : 12'hABC)) begin errors++; $display("FAIL full_issue[%0d]: en %b addr %h", j, a_drpen, a_drpaddr); end
        n = 0;
        if (j == 1) begin
          a_waddr = {2'd0, 12'hABC}; a_raddr = {2'd0, 12'h0CD}; a_wreq = 1'b1; a_rreq = 1'b1;
          tick(); n++;
          a_wreq = 1'b0; a_rreq = 1'b0;
          checks++; if (a_drop !== 1'b1 || a_busy !== 1'b1) begin errors++; $display("FAIL dual_drop: drop %b busy %b want 1 1", a_drop, a_busy); end
        end
      end
      while (a_wfin !== 1'b1 && n < 1100) begin tick(); n++; if (a_rfin === 1'b1) nr++; end
      checks++; if (n !== 1024 || a_err !== 1'b1) begin errors++; $display("FAIL full_timeout[%0d]: cycles %0d err %b want 1024 1", j, n, a_err); end
    end
    repeat (6) begin tick(); if (a_drpen !== 4'b0000 || a_rfin === 1'b1) nr++; end
    checks++; if (nr !== 0 || a_busy !== 1'b0) begin errors++; $display("FAIL full_drain: stray %0d busy %b want 0 0", nr, a_busy); end
    $display("test_fifo_full done");
  endtask

  task automatic test_reset_mid();
    int n;
    a_rdy = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      a_waddr = {2'd1, 12'(12'h100 + i)}; a_wdata = 16'h5A5A; a_wreq = 1'b1;
      tick(); a_wreq = 1'b0;
    end
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checks++; if (a_drpen !== 4'b0000 || a_wfin !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: en %b wfin %b busy %b want 0", a_drpen, a_wfin, a_busy); end
    checks++; if (a_drpaddr !== 12'h0 || a_drpdi !== 16'h0 || a_rdata !== 16'h0) begin errors++; $display("FAIL mid_rst_data: addr %h di %h rdata %h want 0", a_drpaddr, a_drpdi, a_rdata); end
    tick(); tick();
    rst = 1'b0;
    n = 0;
    repeat (40) begin tick(); if (a_drpen !== 4'b0000 || a_wfin === 1'b1 || a_rfin === 1'b1) n++; end
    checks++; if (n !== 0) begin errors++; $display("FAIL mid_rst_flush: activity cycles %0d want 0", n); end
    tick();
    a_waddr = {2'd2, 12'h222}; a_wdata = 16'h2222; a_wreq = 1'b1;
    tick(); a_wreq = 1'b0;
    tick();
    checks++; if (a_drpen !== 4'b0100 || a_drpaddr !== 12'h222) begin errors++; $display("FAIL mid_rst_resume: en %b addr %h want 0100 222", a_drpen, a_drpaddr); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_hold();
    test_bad_channel();
    test_fifo_full();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
